aibcr3_clktree_avmm_mon: RTL and testbench
==========================================

# aibcr3_clktree_avmm_mon

Receive-side monitor for the AVMM strobe clock tree. It samples the tree's replica output and one mimic output in the free-running oscillator domain and counts their rising edges over fixed windows. Each window's counts are checked against an expected range and against each other, and the block reports lock or fault to the AVMM control logic. It sits next to the tree's DLL-replica tap and consumes `lstrbclk_rep` and `lstrbclk_mimic0` as asynchronous data.

## Interface
- `WIN_CYC`, 256: window length in `osc_clk` cycles (power of two, 16–4096)
- `CNT_W`, 9: edge-counter width; must satisfy 2^CNT_W > WIN_CYC/2
- `EXP_MIN`, 60: minimum passing rep edge count per window
- `EXP_MAX`, 68: maximum passing rep edge count per window
- `MAX_DIFF`, 2: maximum allowed |rep_cnt − mimic_cnt|
- `LOCK_WINS`, 4: consecutive passing windows required for lock (1–15)
- `osc_clk` in 1: monitor clock; must be ≥2.5× the monitored clock frequency
- `rstb` in 1: asynchronous, active-low reset
- `mon_en` in 1: level enable; deassertion aborts the current window
- `clk_rep` in 1: replica tree clock, asynchronous
- `clk_mimic` in 1: mimic tree clock, asynchronous
- `mon_locked` out 1: LOCK_WINS consecutive windows passed
- `mon_fault` out 1: last completed window failed
- `fault_code` out 2: 00 none, 01 rep low, 10 rep high, 11 rep/mimic mismatch
- `rep_cnt` out CNT_W: rep count of the last completed window
- `mimic_cnt` out CNT_W: mimic count of the last completed window
- `win_done` out 1: one-cycle pulse when the window result registers update

## Operation
- Each input passes through a 2-flop synchronizer and an edge-detect flop; a rising edge yields a one-cycle `edge` strobe.
- States:
  - IDLE: entered from reset or `mon_en`=0. Moves to SETTLE when `mon_en`=1.
  - SETTLE: lasts 4 cycles. Strobes are ignored and counters are held at 0. Then moves to MEASURE.
  - MEASURE: lasts exactly WIN_CYC cycles. Each strobe increments its counter. Counters saturate at 2^CNT_W−1.
  - CHECK: lasts 1 cycle. Evaluates the window, registers the results, pulses `win_done`, clears the counters, then returns to MEASURE.
- Evaluation priority:
  1. rep_cnt < EXP_MIN → 01
  2. rep_cnt > EXP_MAX → 10
  3. |diff| > MAX_DIFF → 11
  4. otherwise pass
- Pass:
  - `pass_cnt` increments, saturating at LOCK_WINS.
  - `mon_locked`=1 once `pass_cnt`==LOCK_WINS.
  - `mon_fault`=0 and `fault_code`=00.
- Fail: `pass_cnt`=0, `mon_locked`=0, `mon_fault`=1, and `fault_code` is set per the priority above.
- A strobe in the CHECK cycle is dropped. Strobes in the first and last MEASURE cycles are counted.
- Deasserting `mon_en` in any state:
  - Next state is IDLE.
  - Counters, `pass_cnt`, `mon_locked`, `mon_fault` and `fault_code` clear.
  - `rep_cnt` and `mimic_cnt` hold their last values.
  - The partial window is discarded and `win_done` is not pulsed.

## Timing
- Reset values: all outputs 0; state IDLE; synchronizers 0.
- Edge latency: `clk_rep` rise → counter increment in 3 `osc_clk` cycles.
- `mon_en` rise → first MEASURE cycle 5 cycles later (1 cycle IDLE→SETTLE, then 4 SETTLE).
- First `win_done` pulse: 5+WIN_CYC cycles after `mon_en` rise.
- Window period: WIN_CYC+1 cycles.
- All result outputs update together in the cycle `win_done` is high and hold until the next CHECK.
- `rstb` assertion mid-window returns everything to reset values immediately.

## Configuration
- Macro: `AIBCR3_CLKTREE_MON_STICKY_FAULT_EN`.
- Defined:
  - A failing CHECK enters the FAULT state.
  - FAULT holds `mon_fault`=1, `fault_code`, `rep_cnt` and `mimic_cnt` frozen.
  - No further windows run until `mon_en`=0 or `rstb`=0.
- Undefined: FAULT does not exist, and measurement continues after a fail as described in Operation.

## Structure
- Shared package `aibcr3_clkmon_pkg`:
  - state enum
  - `fault_code` constants (FC_NONE, FC_LOW, FC_HIGH, FC_MISM)
  - SETTLE length constant (4)
- Sub-module `aibcr3_clkmon_edgecnt`:
  - synchronizer + edge detect + saturating counter
  - instantiated twice, for rep and mimic
- Top level holds the FSM, window timer, evaluation logic and `pass_cnt`.

## Test plan
- `osc_clk` 1 ns, both clocks 4 ns, `mon_en`=1 at t0 → `win_done` every 257 cycles; counts 64/64; `mon_locked`=1 after the 4th `win_done`; `fault_code`=00.
- `clk_rep` stuck low after lock → next window: `rep_cnt`=0, `fault_code`=01, `mon_fault`=1, `mon_locked`=0; both clocks restored → lock regained 4 windows later (macro undefined).
- `clk_rep` 3.5 ns → count 73, `fault_code`=10.
- Rep 4 ns, mimic 4.2 ns → counts 64/60, diff 4 > 2, `fault_code`=11.
- `mon_en` dropped at cycle 100 of a window → no `win_done`; `mon_locked`=0; counts hold; re-enable → first `win_done` 261 cycles later.
- Macro defined with `clk_rep` stuck → FAULT held for 2000 cycles with no `win_done`; `mon_en` toggled → clean restart.

Source files
------------

// File: rtl/aibcr3_clkmon_pkg.sv
// rtl/aibcr3_clkmon_pkg.sv - shared types and constants for the AVMM clock-tree monitor
// The state set depends on AIBCR3_CLKTREE_MON_STICKY_FAULT_EN.
package aibcr3_clkmon_pkg;

`ifdef AIBCR3_CLKTREE_MON_STICKY_FAULT_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_CHECK,
    ST_FAULT
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_CHECK
  } state_t;
`endif

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_LOW  = 2'b01;
  localparam logic [1:0] FC_HIGH = 2'b10;
  localparam logic [1:0] FC_MISM = 2'b11;

  localparam int SETTLE_CYC = 4;

endpackage

// File: rtl/aibcr3_clkmon_edgecnt.sv
// rtl/aibcr3_clkmon_edgecnt.sv - async clock synchronizer, rising-edge strobe and saturating counter
// cnt_next is the value the counter takes at the coming edge, so a window can be closed on it directly.
module aibcr3_clkmon_edgecnt #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             din,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] cnt_next
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       sync;
  logic             sync_d;
  logic             rise;
  logic [CNT_W-1:0] cnt;

  assign rise = sync[1] & ~sync_d;

  // Counter is held at zero whenever counting is not enabled.
  always_comb begin
    cnt_next = cnt;
    if (!cnt_en) begin
      cnt_next = '0;
    end else if (rise && (cnt != CNT_MAX)) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync   <= 2'b00;
      sync_d <= 1'b0;
      cnt    <= '0;
    end else begin
      sync   <= {sync[0], din};
      sync_d <= sync[1];
      cnt    <= cnt_next;
    end
  end

endmodule

// File: rtl/aibcr3_clktree_avmm_mon.sv
// rtl/aibcr3_clktree_avmm_mon.sv - windowed edge-count lock/fault monitor for the AVMM strobe clock tree
// Optional sticky fault latch: AIBCR3_CLKTREE_MON_STICKY_FAULT_EN.
module aibcr3_clktree_avmm_mon
  import aibcr3_clkmon_pkg::*;
#(
  parameter int WIN_CYC   = 256,
  parameter int CNT_W     = 9,
  parameter int EXP_MIN   = 60,
  parameter int EXP_MAX   = 68,
  parameter int MAX_DIFF  = 2,
  parameter int LOCK_WINS = 4
) (
  input  logic             osc_clk,
  input  logic             rstb,
  input  logic             mon_en,
  input  logic             clk_rep,
  input  logic             clk_mimic,
  output logic             mon_locked,
  output logic             mon_fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] rep_cnt,
  output logic [CNT_W-1:0] mimic_cnt,
  output logic             win_done
);

  localparam int               TMR_W       = $clog2(WIN_CYC);
  localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] EXP_MIN_C   = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0] EXP_MAX_C   = CNT_W'(EXP_MAX);
  localparam logic [CNT_W-1:0] DIFF_C      = CNT_W'(MAX_DIFF);
  localparam logic [3:0]       LOCK_C      = 4'(LOCK_WINS);

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [3:0]       pass_cnt;
  logic [3:0]       pass_nxt;
  logic             cnt_en;
  logic [CNT_W-1:0] rep_nxt;
  logic [CNT_W-1:0] mim_nxt;
  logic [1:0]       win_fc;

  assign cnt_en = mon_en && (state == ST_MEASURE);

  aibcr3_clkmon_edgecnt #(.CNT_W(CNT_W)) u_rep_cnt (
    .clk      (osc_clk),
    .rstb     (rstb),
    .din      (clk_rep),
    .cnt_en   (cnt_en),
    .cnt_next (rep_nxt)
  );

  aibcr3_clkmon_edgecnt #(.CNT_W(CNT_W)) u_mimic_cnt (
    .clk      (osc_clk),
    .rstb     (rstb),
    .din      (clk_mimic),
    .cnt_en   (cnt_en),
    .cnt_next (mim_nxt)
  );

  function automatic logic [1:0] eval_win(input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] m);
    logic [CNT_W-1:0] diff;
    diff = (r > m) ? (r - m) : (m - r);
    if (r < EXP_MIN_C)      return FC_LOW;
    else if (r > EXP_MAX_C) return FC_HIGH;
    else if (diff > DIFF_C) return FC_MISM;
    else                    return FC_NONE;
  endfunction

  // Evaluated on the counters' next values so the last MEASURE cycle's strobe is included.
  assign win_fc   = eval_win(rep_nxt, mim_nxt);
  assign pass_nxt = (pass_cnt >= LOCK_C) ? LOCK_C : (pass_cnt + 4'd1);

  always_ff @(posedge osc_clk or negedge rstb) begin
    if (!rstb) begin
      state      <= ST_IDLE;
      timer      <= '0;
      pass_cnt   <= '0;
      mon_locked <= 1'b0;
      mon_fault  <= 1'b0;
      fault_code <= FC_NONE;
      rep_cnt    <= '0;
      mimic_cnt  <= '0;
      win_done   <= 1'b0;
    end else if (!mon_en) begin
      // Abort: last completed counts stay visible, status clears.
      state      <= ST_IDLE;
      timer      <= '0;
      pass_cnt   <= '0;
      mon_locked <= 1'b0;
      mon_fault  <= 1'b0;
      fault_code <= FC_NONE;
      win_done   <= 1'b0;
    end else begin
      win_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          state <= ST_SETTLE;
          timer <= '0;
        end
        ST_SETTLE: begin
          if (timer == SETTLE_LAST) begin
            state <= ST_MEASURE;
            timer <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_MEASURE: begin
          if (timer == WIN_LAST) begin
            state      <= ST_CHECK;
            timer      <= '0;
            win_done   <= 1'b1;
            rep_cnt    <= rep_nxt;
            mimic_cnt  <= mim_nxt;
            fault_code <= win_fc;
            if (win_fc == FC_NONE) begin
              pass_cnt   <= pass_nxt;
              mon_locked <= (pass_nxt == LOCK_C);
              mon_fault  <= 1'b0;
            end else begin
              pass_cnt   <= '0;
              mon_locked <= 1'b0;
              mon_fault  <= 1'b1;
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
`ifdef AIBCR3_CLKTREE_MON_STICKY_FAULT_EN
        ST_CHECK: state <= mon_fault ? ST_FAULT : ST_MEASURE;
        ST_FAULT: state <= ST_FAULT;
`else
        ST_CHECK: state <= ST_MEASURE;
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aibcr3_clktree_avmm_mon.sv
// tb/tb_aibcr3_clktree_avmm_mon.sv - scoreboard bench for the AVMM clock-tree monitor
module tb_aibcr3_clktree_avmm_mon;
  import aibcr3_clkmon_pkg::*;

  logic       osc_clk   = 1'b0;
  logic       rstb      = 1'b0;
  logic       mon_en    = 1'b0;
  logic       clk_rep   = 1'b0;
  logic       clk_mimic = 1'b0;
  logic       mon_locked;
  logic       mon_fault;
  logic [1:0] fault_code;
  logic [8:0] rep_cnt;
  logic [8:0] mimic_cnt;
  logic       win_done;

  real rep_half  = 2.0;
  real mim_half  = 2.0;
  bit  rep_stuck = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         rmin;
    int         rmax;
    int         mmin;
    int         mmax;
    logic [1:0] fc;
    logic       lk;
    logic       flt;
  } exp_t;

  exp_t sbq[$];

  aibcr3_clktree_avmm_mon dut (
    .osc_clk    (osc_clk),
    .rstb       (rstb),
    .mon_en     (mon_en),
    .clk_rep    (clk_rep),
    .clk_mimic  (clk_mimic),
    .mon_locked (mon_locked),
    .mon_fault  (mon_fault),
    .fault_code (fault_code),
    .rep_cnt    (rep_cnt),
    .mimic_cnt  (mimic_cnt),
    .win_done   (win_done)
  );

  always #0.5ns osc_clk = ~osc_clk;

  // Offset keeps monitored edges clear of osc_clk rising edges.
  initial begin
    #0.27ns;
    forever begin
      #(rep_half * 1ns);
      clk_rep = rep_stuck ? 1'b0 : ~clk_rep;
    end
  end

  initial begin
    #0.27ns;
    forever begin
      #(mim_half * 1ns);
      clk_mimic = ~clk_mimic;
    end
  end

  function automatic void push_exp(input int rmin, input int rmax, input int mmin, input int mmax,
                                   input logic [1:0] fc, input logic lk, input logic flt);
    exp_t e;
    e.rmin = rmin; e.rmax = rmax; e.mmin = mmin; e.mmax = mmax;
    e.fc = fc; e.lk = lk; e.flt = flt;
    sbq.push_back(e);
  endfunction

  task automatic wait_win(input int budget, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    while (cyc < budget && !ok) begin
      @(negedge osc_clk);
      cyc++;
      if (win_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic restart(input real rh, input real mh, input bit stuck);
    @(negedge osc_clk);
    mon_en    = 1'b0;
    rep_half  = rh;
    mim_half  = mh;
    rep_stuck = stuck;
    repeat (8) @(negedge osc_clk);
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    repeat (5) @(negedge osc_clk);
    checks++;
    if ({mon_locked, mon_fault, fault_code, rep_cnt, mimic_cnt, win_done} !== 24'd0) begin
      errors++;
      $display("FAIL reset_state: got lk=%b flt=%b fc=%b rep=%0d mim=%0d wd=%b, want all 0",
               mon_locked, mon_fault, fault_code, rep_cnt, mimic_cnt, win_done);
    end
    rstb = 1'b1;
  endtask

  task automatic test_lock();
    exp_t e;
    bit   ok;
    int   cyc;
    int   n = 0;
    @(negedge osc_clk);
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(64, 64, 64, 64, FC_NONE, (i == 3), 1'b0);
    while (sbq.size() > 0) begin
      wait_win(400, ok, cyc);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL lock_timeout: no win_done after %0d cycles, want one", cyc);
        sbq.delete();
      end else begin
        e = sbq.pop_front();
        if (cyc != ((n == 0) ? 261 : 257)) begin
          errors++;
          $display("FAIL lock_period%0d: got %0d cycles, want %0d", n, cyc, (n == 0) ? 261 : 257);
        end
        checks++;
        if (int'(rep_cnt) < e.rmin || int'(rep_cnt) > e.rmax || int'(mimic_cnt) < e.mmin ||
            int'(mimic_cnt) > e.mmax || {fault_code, mon_locked, mon_fault} !== {e.fc, e.lk, e.flt}) begin
          errors++;
          $display("FAIL lock_win%0d: got rep=%0d mim=%0d fc=%b lk=%b flt=%b, want rep=%0d..%0d mim=%0d..%0d fc=%b lk=%b flt=%b",
                   n, rep_cnt, mimic_cnt, fault_code, mon_locked, mon_fault, e.rmin, e.rmax, e.mmin, e.mmax, e.fc, e.lk, e.flt);
        end
        n++;
      end
    end
  endtask

  task automatic test_rep_stuck();
    exp_t e;
    bit   ok;
    int   cyc;
    int   n = 0;
    rep_stuck = 1'b1;
    push_exp(0, 1, 64, 64, FC_LOW, 1'b0, 1'b1);
    push_exp(62, 64, 64, 64, FC_NONE, 1'b0, 1'b0);
    push_exp(64, 64, 64, 64, FC_NONE, 1'b0, 1'b0);
    push_exp(64, 64, 64, 64, FC_NONE, 1'b0, 1'b0);
    push_exp(64, 64, 64, 64, FC_NONE, 1'b1, 1'b0);
    while (sbq.size() > 0) begin
      wait_win(300, ok, cyc);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL stuck_timeout: no win_done after %0d cycles, want one", cyc);
        sbq.delete();
      end else begin
        e = sbq.pop_front();
        if (int'(rep_cnt) < e.rmin || int'(rep_cnt) > e.rmax || int'(mimic_cnt) < e.mmin ||
            int'(mimic_cnt) > e.mmax || {fault_code, mon_locked, mon_fault} !== {e.fc, e.lk, e.flt}) begin
          errors++;
          $display("FAIL stuck_win%0d: got rep=%0d mim=%0d fc=%b lk=%b flt=%b, want rep=%0d..%0d mim=%0d..%0d fc=%b lk=%b flt=%b",
                   n, rep_cnt, mimic_cnt, fault_code, mon_locked, mon_fault, e.rmin, e.rmax, e.mmin, e.mmax, e.fc, e.lk, e.flt);
        end
        rep_stuck = 1'b0;
        n++;
      end
    end
  endtask

  task automatic test_sticky();
    exp_t e;
    bit   ok;
    int   cyc;
    int   seen = 0;
    restart(2.0, 2.0, 1'b1);
    push_exp(0, 0, 64, 64, FC_LOW, 1'b0, 1'b1);
    push_exp(64, 64, 64, 64, FC_NONE, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      wait_win(300, ok, cyc);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL sticky_timeout: no win_done after %0d cycles, want one", cyc);
      end else begin
        e = sbq.pop_front();
        if (int'(rep_cnt) < e.rmin || int'(rep_cnt) > e.rmax || int'(mimic_cnt) < e.mmin ||
            int'(mimic_cnt) > e.mmax || {fault_code, mon_locked, mon_fault} !== {e.fc, e.lk, e.flt}) begin
          errors++;
          $display("FAIL sticky_win%0d: got rep=%0d mim=%0d fc=%b lk=%b flt=%b, want rep=%0d..%0d mim=%0d..%0d fc=%b lk=%b flt=%b",
                   k, rep_cnt, mimic_cnt, fault_code, mon_locked, mon_fault, e.rmin, e.rmax, e.mmin, e.mmax, e.fc, e.lk, e.flt);
        end
      end
      if (k == 0) begin
        repeat (2000) begin
          @(negedge osc_clk);
          if (win_done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || {mon_fault, fault_code, rep_cnt, mimic_cnt} !== {1'b1, FC_LOW, 9'd0, 9'd64}) begin
          errors++;
          $display("FAIL sticky_hold: got wd_count=%0d flt=%b fc=%b rep=%0d mim=%0d, want 0 1 01 0 64",
                   seen, mon_fault, fault_code, rep_cnt, mimic_cnt);
        end
        restart(2.0, 2.0, 1'b0);
      end
    end
    sbq.delete();
  endtask

  task automatic test_rep_high();
    exp_t e;
    bit   ok;
    int   cyc;
    restart(1.75, 2.0, 1'b0);
    push_exp(73, 74, 64, 64, FC_HIGH, 1'b0, 1'b1);
    while (sbq.size() > 0) begin
      wait_win(300, ok, cyc);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL high_timeout: no win_done after %0d cycles, want one", cyc);
        sbq.delete();
      end else begin
        e = sbq.pop_front();
        if (int'(rep_cnt) < e.rmin || int'(rep_cnt) > e.rmax || int'(mimic_cnt) < e.mmin ||
            int'(mimic_cnt) > e.mmax || {fault_code, mon_locked, mon_fault} !== {e.fc, e.lk, e.flt}) begin
          errors++;
          $display("FAIL high_win: got rep=%0d mim=%0d fc=%b lk=%b flt=%b, want rep=%0d..%0d mim=%0d..%0d fc=%b lk=%b flt=%b",
                   rep_cnt, mimic_cnt, fault_code, mon_locked, mon_fault, e.rmin, e.rmax, e.mmin, e.mmax, e.fc, e.lk, e.flt);
        end
      end
    end
  endtask

  task automatic test_mismatch();
    exp_t e;
    bit   ok;
    int   cyc;
    restart(2.0, 2.1, 1'b0);
    push_exp(64, 64, 60, 61, FC_MISM, 1'b0, 1'b1);
    while (sbq.size() > 0) begin
      wait_win(300, ok, cyc);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL mism_timeout: no win_done after %0d cycles, want one", cyc);
        sbq.delete();
      end else begin
        e = sbq.pop_front();
        if (int'(rep_cnt) < e.rmin || int'(rep_cnt) > e.rmax || int'(mimic_cnt) < e.mmin ||
            int'(mimic_cnt) > e.mmax || {fault_code, mon_locked, mon_fault} !== {e.fc, e.lk, e.flt}) begin
          errors++;
          $display("FAIL mism_win: got rep=%0d mim=%0d fc=%b lk=%b flt=%b, want rep=%0d..%0d mim=%0d..%0d fc=%b lk=%b flt=%b",
                   rep_cnt, mimic_cnt, fault_code, mon_locked, mon_fault, e.rmin, e.rmax, e.mmin, e.mmax, e.fc, e.lk, e.flt);
        end
      end
    end
  endtask

  task automatic test_en_drop();
    exp_t e;
    bit   ok;
    int   cyc;
    int   seen = 0;
    restart(2.0, 2.0, 1'b0);
    push_exp(64, 64, 64, 64, FC_NONE, 1'b0, 1'b0);
    push_exp(64, 64, 64, 64, FC_NONE, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      wait_win(300, ok, cyc);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL drop_timeout: no win_done after %0d cycles, want one", cyc);
      end else begin
        e = sbq.pop_front();
        if (int'(rep_cnt) < e.rmin || int'(rep_cnt) > e.rmax || int'(mimic_cnt) < e.mmin ||
            int'(mimic_cnt) > e.mmax || {fault_code, mon_locked, mon_fault} !== {e.fc, e.lk, e.flt}) begin
          errors++;
          $display("FAIL drop_win%0d: got rep=%0d mim=%0d fc=%b lk=%b flt=%b, want rep=%0d..%0d mim=%0d..%0d fc=%b lk=%b flt=%b",
                   k, rep_cnt, mimic_cnt, fault_code, mon_locked, mon_fault, e.rmin, e.rmax, e.mmin, e.mmax, e.fc, e.lk, e.flt);
        end
      end
    end
    sbq.delete();
    repeat (100) @(negedge osc_clk);
    mon_en = 1'b0;
    repeat (300) begin
      @(negedge osc_clk);
      if (win_done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL drop_no_win_done: got %0d pulses, want 0", seen);
    end
    checks++;
    if ({mon_locked, mon_fault, fault_code, rep_cnt, mimic_cnt} !== {1'b0, 1'b0, FC_NONE, 9'd64, 9'd64}) begin
      errors++;
      $display("FAIL drop_status: got lk=%b flt=%b fc=%b rep=%0d mim=%0d, want 0 0 00 64 64",
               mon_locked, mon_fault, fault_code, rep_cnt, mimic_cnt);
    end
    mon_en = 1'b1;
    push_exp(64, 64, 64, 64, FC_NONE, 1'b0, 1'b0);
    wait_win(400, ok, cyc);
    checks++;
    if (!ok || cyc != 261) begin
      errors++;
      $display("FAIL drop_reenable_latency: got ok=%0d after %0d cycles, want win_done at 261", ok, cyc);
    end else begin
      e = sbq.pop_front();
      checks++;
      if (int'(rep_cnt) < e.rmin || int'(rep_cnt) > e.rmax || int'(mimic_cnt) < e.mmin ||
          int'(mimic_cnt) > e.mmax || {fault_code, mon_locked, mon_fault} !== {e.fc, e.lk, e.flt}) begin
        errors++;
        $display("FAIL drop_reenable_win: got rep=%0d mim=%0d fc=%b lk=%b flt=%b, want rep=%0d mim=%0d fc=%b lk=%b flt=%b",
                 rep_cnt, mimic_cnt, fault_code, mon_locked, mon_fault, e.rmin, e.mmin, e.fc, e.lk, e.flt);
      end
    end
    sbq.delete();
  endtask

  task automatic test_async_reset();
    bit ok;
    int cyc;
    restart(2.0, 2.0, 1'b0);
    wait_win(300, ok, cyc);
    checks++;
    if (!ok || rep_cnt !== 9'd64) begin
      errors++;
      $display("FAIL areset_prewin: got ok=%0d rep=%0d, want win_done with rep=64", ok, rep_cnt);
    end
    repeat (50) @(negedge osc_clk);
    #0.2ns;
    rstb = 1'b0;
    #0.1ns;
    checks++;
    if ({mon_locked, mon_fault, fault_code, rep_cnt, mimic_cnt, win_done} !== 24'd0) begin
      errors++;
      $display("FAIL areset_clear: got lk=%b flt=%b fc=%b rep=%0d mim=%0d wd=%b, want all 0",
               mon_locked, mon_fault, fault_code, rep_cnt, mimic_cnt, win_done);
    end
    @(negedge osc_clk);
    rstb = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock();
`ifdef AIBCR3_CLKTREE_MON_STICKY_FAULT_EN
    test_sticky();
`else
    test_rep_stuck();
`endif
    test_rep_high();
    test_mismatch();
    test_en_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
